tea_arbiter: RTL and testbench

TEA_ARBITER -- requirements
Module: tea_arbiter

---
 rtl/tea_arbiter.sv | 143 ++++++++++++++
 tb/tb_tea_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tea_arbiter.sv
// Round-robin arbiter that shares one cipher core among N requesters.
// Grants are made from IDLE, the operand is handed to the core, and the
// result is returned to the winning requester with a one-cycle done pulse.
// A per-transaction watchdog forces completion, with a zero result and a
// sticky error flag, if the core never finishes.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no transaction; arbitrate when the core is idle and hold is low
// ISSUE  | core_req high; wait for the core to drop core_ack (accepted)
// BUSY   | core computing; wait for core_ack to return high (result valid)
// DONE   | pulse done to the owner, advance the round-robin pointer

module tea_arbiter #(
    parameter int          N       = 4,
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [32*N-1:0] wdata,
    output logic [N-1:0]    done,
    output logic [31:0]     rdata,
    output logic [1:0]      rid,
    output logic            err,
    output logic            busy,
    input  logic            hold,
    output logic            core_req,
    output logic [31:0]     core_wdata,
    input  logic            core_ack,
    input  logic [31:0]     core_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  rid_q, rid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] core_wdata_q, core_wdata_d;
    logic        err_q, err_d;
    logic [15:0] wd_q, wd_d;

    logic        grant_vld;
    logic [1:0]  grant_idx;
    logic [1:0]  cand;

    // Round-robin search: first pending request strictly after the last owner.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 2'd0;
        cand      = 2'd0;
        for (int i = 1; i <= N; i++) begin
            cand = 2'((int'(ptr_q) + i) % N);
            if (!grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Next-state logic for the transaction FSM, watchdog and result capture.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        rid_d        = rid_q;
        rdata_d      = rdata_q;
        core_wdata_d = core_wdata_q;
        err_d        = err_q;
        wd_d         = wd_q;

        unique case (state_q)
            S_IDLE: begin
                if (grant_vld && !hold && core_ack) begin
                    state_d      = S_ISSUE;
                    rid_d        = grant_idx;
                    core_wdata_d = wdata[32*int'(grant_idx) +: 32];
                    wd_d         = 16'd0;
                end
            end
            S_ISSUE, S_BUSY: begin
                wd_d = wd_q + 16'd1;
                // A stuck core must not hang the requester; the watchdog wins
                // over any core handshake seen on the same edge.
                if (wd_d == TIMEOUT) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                end else if (state_q == S_ISSUE) begin
                    if (!core_ack) state_d = S_BUSY;
                end else if (core_ack) begin
                    state_d = S_DONE;
                    rdata_d = core_rdata;
                end
            end
            S_DONE: begin
                ptr_d   = rid_q;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset points the pointer at N-1 so that
    // requester 0 has first priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= 2'(N - 1);
            rid_q        <= 2'd0;
            rdata_q      <= 32'd0;
            core_wdata_q <= 32'd0;
            err_q        <= 1'b0;
            wd_q         <= 16'd0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            rid_q        <= rid_d;
            rdata_q      <= rdata_d;
            core_wdata_q <= core_wdata_d;
            err_q        <= err_d;
            wd_q         <= wd_d;
        end
    end

    // Outputs decoded straight from state so they track the FSM with no lag.
    always_comb begin
        core_req = (state_q == S_ISSUE);
        busy     = (state_q != S_IDLE);
        done     = '0;
        if (state_q == S_DONE) done = {{(N-1){1'b0}}, 1'b1} << rid_q;
    end

    assign rdata      = rdata_q;
    assign rid        = rid_q;
    assign err        = err_q;
    assign core_wdata = core_wdata_q;

endmodule

// File: tb/tb_tea_arbiter.sv
// Directed bench for tea_arbiter with a simple behavioural cipher core.
module tb_tea_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  req = '0;
    logic [127:0]  wdata = '0;
    logic [N-1:0]  done;
    logic [31:0]   rdata;
    logic [1:0]    rid;
    logic          err;
    logic          busy;
    logic          hold = 1'b0;
    logic          core_req;
    logic [31:0]   core_wdata;
    logic          core_ack;
    logic [31:0]   core_rdata = '0;

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;

    // core model state
    logic        core_ack_r = 1'b1;
    logic        ack_stuck = 1'b0;
    int          core_cnt = 0;
    int          round_cfg = 1;
    logic [31:0] core_opnd = '0;

    tea_arbiter #(.N(N), .TIMEOUT(16'd16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .wdata      (wdata),
        .done       (done),
        .rdata      (rdata),
        .rid        (rid),
        .err        (err),
        .busy       (busy),
        .hold       (hold),
        .core_req   (core_req),
        .core_wdata (core_wdata),
        .core_ack   (core_ack),
        .core_rdata (core_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [31:0] core_fn(input logic [31:0] x);
        return {x[15:0], x[31:16]} ^ 32'hDEADBEEF;
    endfunction

    // Core: accepts on core_req while idle, computes round_cfg cycles, then
    // raises core_ack together with the result. It ignores the arbiter reset.
    always @(posedge clk) begin
        if (!ack_stuck) begin
            if (core_ack_r && core_req) begin
                core_ack_r <= 1'b0;
                core_cnt   <= round_cfg;
                core_opnd  <= core_wdata;
            end else if (!core_ack_r) begin
                if (core_cnt <= 1) begin
                    core_ack_r <= 1'b1;
                    core_rdata <= core_fn(core_opnd);
                end else begin
                    core_cnt <= core_cnt - 1;
                end
            end
        end
    end
    assign core_ack = core_ack_r | ack_stuck;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (done !== '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (core_req !== 1'b0) begin errors++; $display("FAIL reset_core_req got=%b exp=0", core_req); end
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done got=%b exp=0000", done); end
        checks++; if (rid !== 2'd0) begin errors++; $display("FAIL reset_rid got=%0d exp=0", rid); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        checks++; if (core_wdata !== 32'd0) begin errors++; $display("FAIL reset_core_wdata got=%h exp=0", core_wdata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    endtask

    task automatic test_single();
        int  n_req;
        bit  ok;
        do_reset();
        wdata[31:0] = 32'h12345678;
        req = 4'b0001;
        n_req = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (core_req === 1'b1) n_req++;
            if (done !== '0) begin
                ok = 1'b1;
                break;
            end
        end
        req = 4'b0000;
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout got=no_done exp=done"); end
        checks++; if (n_req != 2) begin errors++; $display("FAIL single_core_req_cycles got=%0d exp=2", n_req); end
        checks++; if (done !== 4'b0001) begin errors++; $display("FAIL single_done got=%b exp=0001", done); end
        checks++; if (rid !== 2'd0) begin errors++; $display("FAIL single_rid got=%0d exp=0", rid); end
        checks++; if (rdata !== 32'h88D5ACDB) begin errors++; $display("FAIL single_rdata got=%h exp=88d5acdb", rdata); end
        step();
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL single_done_width got=%b exp=0000", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got=%b exp=0", busy); end
    endtask

    task automatic test_all_pending();
        bit ok;
        int last;
        logic [1:0] exp_id;
        do_reset();
        for (int i = 0; i < N; i++) wdata[32*i +: 32] = 32'hA0000000 + 32'h01111111 * (i + 1);
        req = 4'b1111;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            exp_id = 2'(k % 4);
            wait_done(ok);
            checks++; if (!ok) begin errors++; $display("FAIL rr_timeout k=%0d got=no_done exp=done", k); end
            checks++; if (rid !== exp_id) begin errors++; $display("FAIL rr_order k=%0d got=%0d exp=%0d", k, rid, exp_id); end
            checks++; if (done !== (4'b0001 << exp_id)) begin errors++; $display("FAIL rr_done k=%0d got=%b exp=%b", k, done, 4'b0001 << exp_id); end
            checks++; if (rdata !== core_fn(wdata[32*exp_id +: 32])) begin errors++; $display("FAIL rr_rdata k=%0d got=%h exp=%h", k, rdata, core_fn(wdata[32*exp_id +: 32])); end
            if (k > 0) begin
                checks++; if (cyc_cnt - last != 5) begin errors++; $display("FAIL rr_spacing k=%0d got=%0d exp=5", k, cyc_cnt - last); end
            end
            last = cyc_cnt;
        end
        req = 4'b0000;
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_idle got=busy exp=idle"); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [1:0] exp_seq [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
        do_reset();
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            wait_done(ok);
            checks++; if (!ok || rid !== exp_seq[k]) begin errors++; $display("FAIL b2b_order k=%0d got=%0d exp=%0d", k, rid, exp_seq[k]); end
        end
        req = 4'b0000;
        wait_idle(ok);
    endtask

    task automatic test_hold();
        bit ok;
        int bad;
        do_reset();
        wdata[63:32] = 32'hCAFEF00D;
        hold = 1'b1;
        req = 4'b0010;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (core_req !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL hold_inhibit got=%0d_bad_cycles exp=0", bad); end
        hold = 1'b0;
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_release_grant got=%b exp=1", busy); end
        checks++; if (rid !== 2'd1) begin errors++; $display("FAIL hold_rid got=%0d exp=1", rid); end
        checks++; if (core_wdata !== 32'hCAFEF00D) begin errors++; $display("FAIL hold_core_wdata got=%h exp=cafef00d", core_wdata); end
        hold = 1'b1;
        wait_done(ok);
        checks++; if (!ok || done !== 4'b0010) begin errors++; $display("FAIL hold_after_grant got=%b exp=0010", done); end
        checks++; if (rdata !== core_fn(32'hCAFEF00D)) begin errors++; $display("FAIL hold_rdata got=%h exp=%h", rdata, core_fn(32'hCAFEF00D)); end
        hold = 1'b0;
        req = 4'b0000;
        wait_idle(ok);
    endtask

    task automatic test_timeout();
        bit ok;
        int early;
        do_reset();
        ack_stuck = 1'b1;
        req = 4'b0001;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (busy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        req = 4'b0000;
        checks++; if (!ok) begin errors++; $display("FAIL to_grant got=no_grant exp=grant"); end
        early = 0;
        for (int i = 1; i <= 15; i++) begin
            step();
            if (done !== 4'b0000 || err !== 1'b0) early++;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL to_early got=%0d_cycles exp=0", early); end
        step();
        checks++; if (done !== 4'b0001) begin errors++; $display("FAIL to_done got=%b exp=0001", done); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err got=%b exp=1", err); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL to_rdata got=%h exp=0", rdata); end
        ack_stuck = 1'b0;
        step();
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL to_done_width got=%b exp=0000", done); end
        wdata[95:64] = 32'h0BADCAFE;
        req = 4'b0100;
        wait_done(ok);
        req = 4'b0000;
        checks++; if (!ok || rid !== 2'd2) begin errors++; $display("FAIL to_continue_rid got=%0d exp=2", rid); end
        checks++; if (rdata !== core_fn(32'h0BADCAFE)) begin errors++; $display("FAIL to_continue_rdata got=%h exp=%h", rdata, core_fn(32'h0BADCAFE)); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err_sticky got=%b exp=1", err); end
        wait_idle(ok);
    endtask

    task automatic test_reset_midop();
        bit ok;
        round_cfg = 6;
        wdata[31:0] = 32'h55AA33CC;
        req = 4'b0100;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy === 1'b1 && core_req === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok) begin errors++; $display("FAIL rmid_reach_busy got=no exp=yes"); end
        req = 4'b0101;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        checks++; if (core_req !== 1'b0) begin errors++; $display("FAIL rmid_core_req got=%b exp=0", core_req); end
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL rmid_done got=%b exp=0000", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rmid_err got=%b exp=0", err); end
        wait_done(ok);
        req = 4'b0000;
        checks++; if (!ok || done !== 4'b0001) begin errors++; $display("FAIL rmid_next_grant got=%b exp=0001", done); end
        checks++; if (rdata !== core_fn(32'h55AA33CC)) begin errors++; $display("FAIL rmid_rdata got=%h exp=%h", rdata, core_fn(32'h55AA33CC)); end
        round_cfg = 1;
        wait_idle(ok);
    endtask

    task automatic test_early_drop();
        bit ok;
        do_reset();
        wdata[31:0] = 32'h0F1E2D3C;
        req = 4'b0001;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (busy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        step();
        req = 4'b0000;
        wait_done(ok);
        checks++; if (!ok || done !== 4'b0001) begin errors++; $display("FAIL drop_done got=%b exp=0001", done); end
        checks++; if (rdata !== core_fn(32'h0F1E2D3C)) begin errors++; $display("FAIL drop_rdata got=%h exp=%h", rdata, core_fn(32'h0F1E2D3C)); end
        step();
        checks++; if (done !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL drop_after got=done%b_busy%b exp=done0000_busy0", done, busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_pending();
        test_back_to_back();
        test_hold();
        test_timeout();
        test_reset_midop();
        test_early_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
